// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types and constants for the LED arbiter
package led_pkg;

    typedef logic [2:0] colour_t;

    localparam colour_t LED_OFF = 3'b000;

    // Wide enough for any legal MAX_HOLD (up to 255)
    localparam int HOLD_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } arb_state_t;

    typedef enum logic {
        SERVED_A = 1'b0,
        SERVED_B = 1'b1
    } served_t;

endpackage

// File: rtl/led_hold_timer.sv
// rtl/led_hold_timer.sv - saturating grant hold counter with MIN/MAX flags
module led_hold_timer
    import led_pkg::*;
#(
    parameter int MIN_HOLD = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic min_reached,
    output logic max_reached
);

    localparam logic [HOLD_W-1:0] MIN_C = HOLD_W'(MIN_HOLD);
    localparam logic [HOLD_W-1:0] MAX_C = HOLD_W'(MAX_HOLD);

    logic [HOLD_W-1:0] count;

    // Count value equals the number of cycles the current owner has held the LED
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= HOLD_W'(1);
        end else if (enable && (count < MAX_C)) begin
            count <= count + HOLD_W'(1);
        end
    end

    assign min_reached = (count >= MIN_C);
    assign max_reached = (count >= MAX_C);

endmodule

// File: rtl/led_arbiter.sv
// rtl/led_arbiter.sv - two-requester LED arbiter with min/max hold times
module led_arbiter
    import led_pkg::*;
#(
    parameter int MIN_HOLD = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic [2:0] colour_a,
    input  logic       req_b,
    input  logic [2:0] colour_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic [2:0] colour,
    output logic       busy
);

    arb_state_t state;
    arb_state_t state_next;
    served_t    last_served;
    colour_t    colour_next;
    logic       hold_load;
    logic       hold_enable;
    logic       min_reached;
    logic       max_reached;

    led_hold_timer #(
        .MIN_HOLD (MIN_HOLD),
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_timer (
        .clk         (clk),
        .rst         (rst),
        .load        (hold_load),
        .enable      (hold_enable),
        .min_reached (min_reached),
        .max_reached (max_reached)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_a && req_b) begin
                    state_next = (last_served == SERVED_B) ? ST_OWN_A : ST_OWN_B;
                end else if (req_a) begin
                    state_next = ST_OWN_A;
                end else if (req_b) begin
                    state_next = ST_OWN_B;
                end
            end
            ST_OWN_A: begin
                // Release after min hold, or yield to a waiting B after max hold
                if ((!req_a && min_reached) || (max_reached && req_b)) begin
                    state_next = req_b ? ST_OWN_B : ST_IDLE;
                end
            end
            ST_OWN_B: begin
                if ((!req_b && min_reached) || (max_reached && req_a)) begin
                    state_next = req_a ? ST_OWN_A : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        hold_load   = (state_next != ST_IDLE) && (state_next != state);
        hold_enable = (state_next != ST_IDLE) && (state_next == state);
        case (state_next)
            ST_OWN_A: colour_next = colour_a;
            ST_OWN_B: colour_next = colour_b;
            default:  colour_next = LED_OFF;
        endcase
    end

    // Outputs are registered from the next state so they align with the grant
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            last_served <= SERVED_B;
            gnt_a       <= 1'b0;
            gnt_b       <= 1'b0;
            busy        <= 1'b0;
            colour      <= LED_OFF;
        end else begin
            state <= state_next;
            if (hold_load) begin
                last_served <= (state_next == ST_OWN_A) ? SERVED_A : SERVED_B;
            end
            gnt_a  <= (state_next == ST_OWN_A);
            gnt_b  <= (state_next == ST_OWN_B);
            busy   <= (state_next != ST_IDLE);
            colour <= colour_next;
        end
    end

endmodule

// File: tb/tb_led_arbiter.sv
// tb/tb_led_arbiter.sv - self-checking bench for led_arbiter
module tb_led_arbiter;

    localparam int MIN_HOLD = 4;
    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a;
    logic [2:0] colour_a;
    logic       req_b;
    logic [2:0] colour_b;
    logic       gnt_a;
    logic       gnt_b;
    logic [2:0] colour;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Reference model: owner 0=none, 1=A, 2=B; held = cycles owned so far
    int         m_owner = 0;
    int         m_held  = 0;
    int         m_last  = 2;
    logic [2:0] m_colour = 3'b000;

    always #5 clk = ~clk;

    led_arbiter #(
        .MIN_HOLD (MIN_HOLD),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_a    (req_a),
        .colour_a (colour_a),
        .req_b    (req_b),
        .colour_b (colour_b),
        .gnt_a    (gnt_a),
        .gnt_b    (gnt_b),
        .colour   (colour),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic ra, input logic [2:0] ca,
                              input logic rb, input logic [2:0] cb);
        int  nxt;
        bit  mine, other;
        if (r) begin
            m_owner  = 0;
            m_held   = 0;
            m_last   = 2;
            m_colour = 3'b000;
            return;
        end
        nxt = m_owner;
        if (m_owner == 0) begin
            if (ra && rb)  nxt = (m_last == 2) ? 1 : 2;
            else if (ra)   nxt = 1;
            else if (rb)   nxt = 2;
        end else begin
            mine  = (m_owner == 1) ? ra : rb;
            other = (m_owner == 1) ? rb : ra;
            if ((!mine && m_held >= MIN_HOLD) || (m_held >= MAX_HOLD && other))
                nxt = other ? (3 - m_owner) : 0;
        end
        if (nxt != 0 && nxt != m_owner) begin
            m_held = 1;
            m_last = nxt;
        end else if (nxt != 0 && m_held < MAX_HOLD) begin
            m_held = m_held + 1;
        end
        m_owner  = nxt;
        m_colour = (nxt == 1) ? ca : (nxt == 2) ? cb : 3'b000;
    endtask

    // One clock: drive inputs, advance model at the edge, compare at negedge
    task automatic cyc(input logic r, input logic ra, input logic [2:0] ca,
                       input logic rb, input logic [2:0] cb);
        rst = r; req_a = ra; colour_a = ca; req_b = rb; colour_b = cb;
        @(posedge clk);
        model_step(r, ra, ca, rb, cb);
        @(negedge clk);
        chk("model_gnt_a",  {2'b00, gnt_a},  {2'b00, m_owner == 1});
        chk("model_gnt_b",  {2'b00, gnt_b},  {2'b00, m_owner == 2});
        chk("model_busy",   {2'b00, busy},   {2'b00, m_owner != 0});
        chk("model_colour", colour, m_colour);
        chk("exclusive",    {2'b00, gnt_a & gnt_b}, 3'd0);
    endtask

    initial begin
        rst = 1'b1; req_a = 1'b0; colour_a = 3'd0; req_b = 1'b0; colour_b = 3'd0;
        @(negedge clk);

        // Reset for two cycles
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 3'd5, 1, 3'd6);
        chk("rst_gnt_a", {2'b00, gnt_a}, 3'd0);
        chk("rst_gnt_b", {2'b00, gnt_b}, 3'd0);
        chk("rst_busy",  {2'b00, busy},  3'd0);
        chk("rst_colour", colour, 3'b000);

        // Single one-cycle request from A gets exactly MIN_HOLD grant cycles
        cyc(0, 1, 3'b011, 0, 3'd0);
        chk("short_first_gnt", {2'b00, gnt_a}, 3'd1);
        chk("short_first_col", colour, 3'b011);
        for (int i = 1; i < MIN_HOLD; i++) begin
            cyc(0, 0, 3'b011, 0, 3'd7);
            chk("short_hold_gnt", {2'b00, gnt_a}, 3'd1);
            chk("short_hold_col", colour, 3'b011);
        end
        cyc(0, 0, 3'b011, 0, 3'd7);
        chk("short_release_gnt", {2'b00, gnt_a}, 3'd0);
        chk("short_release_col", colour, 3'b000);

        // Simultaneous requests: A first, then B with no idle gap
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 3'b001, 1, 3'b110);
            chk("tie_a_gnt", {2'b00, gnt_a}, 3'd1);
            chk("tie_a_col", colour, 3'b001);
        end
        cyc(0, 0, 3'b001, 1, 3'b110);
        chk("handover_gnt_b", {2'b00, gnt_b}, 3'd1);
        chk("handover_col",   colour, 3'b110);

        // Permanent contention alternates every MAX_HOLD cycles
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 3 * MAX_HOLD; i++) begin
            logic a_turn;
            a_turn = ((i / MAX_HOLD) % 2) == 0;
            cyc(0, 1, 3'b010, 1, 3'b101);
            chk("alt_gnt_a", {2'b00, gnt_a}, {2'b00, a_turn});
            chk("alt_gnt_b", {2'b00, gnt_b}, {2'b00, !a_turn});
            chk("alt_col", colour, a_turn ? 3'b010 : 3'b101);
        end

        // Uncontested owner keeps the grant past MAX_HOLD, then yields at once
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            cyc(0, 1, 3'b100, 0, 3'b111);
            chk("solo_gnt_a", {2'b00, gnt_a}, 3'd1);
        end
        cyc(0, 1, 3'b100, 1, 3'b111);
        chk("preempt_gnt_b", {2'b00, gnt_b}, 3'd1);
        chk("preempt_col", colour, 3'b111);

        // Reset in the fifth cycle of a B grant, then A wins the next tie
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < MAX_HOLD + 4; i++) cyc(0, 1, 3'b001, 1, 3'b011);
        chk("pre_reset_gnt_b", {2'b00, gnt_b}, 3'd1);
        cyc(1, 1, 3'b001, 1, 3'b011);
        chk("midrst_gnt_a", {2'b00, gnt_a}, 3'd0);
        chk("midrst_gnt_b", {2'b00, gnt_b}, 3'd0);
        chk("midrst_busy",  {2'b00, busy},  3'd0);
        chk("midrst_col",   colour, 3'b000);
        cyc(0, 1, 3'b001, 1, 3'b011);
        chk("postrst_gnt_a", {2'b00, gnt_a}, 3'd1);
        chk("postrst_col",   colour, 3'b001);

        // Randomised traffic against the model, with occasional resets
        for (int i = 0; i < 600; i++) begin
            logic       r, ra, rb;
            logic [2:0] ca, cb;
            r  = ($urandom_range(0, 59) == 0);
            ra = ($urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 8 : 3));
            rb = ($urandom_range(0, 9) < ((i / 150) % 2 == 0 ? 7 : 2));
            ca = 3'($urandom_range(0, 7));
            cb = 3'($urandom_range(0, 7));
            cyc(r, ra, ca, rb, cb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
